// File: rtl/data_mem_requester.sv
// Load/store requester for the dataMem port: issues one access at a time and aligns/extends load data.
// Optional build macro DMR_MISALIGN_TRAP_EN reports misaligned requests through rsp_err instead of accessing memory.
module data_mem_requester #(
  parameter int ADDR_W = 64,
  parameter int XLEN   = 64,
  parameter int MEM_DW = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [MEM_DW-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  state_e              state_q;
  logic                store_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [1:0]          lane_q;
  logic [2:0]          cnt_q;
  logic                req_ready_q;
  logic                mem_en_q;
  logic                mem_rw_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [XLEN-1:0]     mem_wdata_q;
  logic [3:0]          mem_be_q;
  logic                rsp_valid_q;
  logic [XLEN-1:0]     rsp_data_q;

  logic [ADDR_W-1:0]   mem_addr_d;
  logic [MEM_DW-1:0]   wword_d;
  logic [XLEN-1:0]     mem_wdata_d;
  logic [3:0]          mem_be_d;
  logic [MEM_DW-1:0]   rd_byte_sh;
  logic [MEM_DW-1:0]   rd_half_sh;
  logic [XLEN-1:0]     load_data_d;
  logic                unused_wdata_hi;

  // Only the low word of store data ever reaches the memory lanes.
  assign unused_wdata_hi = ^req_wdata[XLEN-1:MEM_DW];

  assign mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wword_d  = req_wdata[MEM_DW-1:0];
    mem_be_d = 4'b1111;
    case (req_size)
      SZ_BYTE: begin
        wword_d  = {24'b0, req_wdata[7:0]} << {req_addr[1:0], 3'b000};
        mem_be_d = 4'b0001 << req_addr[1:0];
      end
      SZ_HALF: begin
        wword_d  = {16'b0, req_wdata[15:0]} << {req_addr[1], 4'b0000};
        mem_be_d = 4'b0011 << {req_addr[1], 1'b0};
      end
      default: begin
        wword_d  = req_wdata[MEM_DW-1:0];
        mem_be_d = 4'b1111;
      end
    endcase
    mem_wdata_d = {{(XLEN-MEM_DW){1'b0}}, wword_d};
  end

  assign rd_byte_sh = mem_rdata >> {lane_q, 3'b000};
  assign rd_half_sh = mem_rdata >> {lane_q[1], 4'b0000};

  always_comb begin
    load_data_d = '0;
    case (size_q)
      SZ_BYTE: load_data_d = {{(XLEN-8){signed_q & rd_byte_sh[7]}}, rd_byte_sh[7:0]};
      SZ_HALF: load_data_d = {{(XLEN-16){signed_q & rd_half_sh[15]}}, rd_half_sh[15:0]};
      default: load_data_d = {{(XLEN-MEM_DW){signed_q & mem_rdata[MEM_DW-1]}}, mem_rdata};
    endcase
  end

`ifdef DMR_MISALIGN_TRAP_EN
  logic misaligned;
  logic rsp_err_q;

  assign misaligned = (req_size == SZ_HALF) ? req_addr[0]
                    : (req_size == SZ_BYTE) ? 1'b0
                    : (req_addr[1:0] != 2'b00);
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      lane_q      <= 2'b00;
      cnt_q       <= 3'd0;
      req_ready_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef DMR_MISALIGN_TRAP_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            store_q     <= req_rw;
            size_q      <= req_size;
            signed_q    <= req_signed;
            lane_q      <= req_addr[1:0];
`ifdef DMR_MISALIGN_TRAP_EN
            if (misaligned) begin
              // Trapped requests never touch memory; the error response is ready next cycle.
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end else
`endif
            begin
              state_q     <= S_ISSUE;
              mem_en_q    <= 1'b1;
              mem_rw_q    <= req_rw;
              mem_addr_q  <= mem_addr_d;
              mem_wdata_q <= req_rw ? mem_wdata_d : '0;
              mem_be_q    <= req_rw ? mem_be_d : 4'b0000;
            end
          end
        end

        S_ISSUE: begin
          mem_en_q <= 1'b0;
          if (store_q) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= 3'd1;
          end
        end

        S_WAIT: begin
          // cnt_q numbers the cycles after the enable pulse; read data is valid on the last one.
          if (cnt_q == RD_LAT_C) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= load_data_d;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
`ifdef DMR_MISALIGN_TRAP_EN
            rsp_err_q   <= 1'b0;
`endif
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_data_mem_requester.sv
// Scoreboard bench for data_mem_requester: directed loads/stores, back-pressure, mid-access reset.
// Define DMR_MISALIGN_TRAP_EN for both bench and RTL to exercise the misaligned trap build.
module tb_data_mem_requester;

  localparam int ADDR_W = 64;
  localparam int XLEN   = 64;
  localparam int MEM_DW = 32;
  localparam int RD_LAT = 1;
  localparam logic [31:0] JUNK = 32'h5A5A_A5A5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_rw = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [XLEN-1:0]   req_wdata = '0;
  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [3:0]        mem_be;
  logic [MEM_DW-1:0] mem_rdata = JUNK;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [XLEN-1:0]   rsp_data;
  logic              rsp_err;

  data_mem_requester #(
    .ADDR_W(ADDR_W), .XLEN(XLEN), .MEM_DW(MEM_DW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic        rw;
    logic [3:0]  be;
    logic [31:0] wd;
    int          cyc;
  } mem_t;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    bit          rw;
    bit [1:0]    size;
    bit          sgn;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [63:0] data;
    bit          mis;
  } vec_t;

  mem_t        mem_q[$];
  rsp_t        rsp_q[$];
  vec_t        vecs[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  logic [31:0] rd_word = JUNK;
  logic        prev_v = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read word is driven only in the cycle RD_LAT after the enable pulse.
  always @(posedge clk) begin
    automatic bit rd_fire = mem_en && !mem_rw;
    #1;
    if (rst)                rd_cnt = 0;
    else if (rd_fire)       rd_cnt = 1;
    else if (rd_cnt != 0)   rd_cnt = (rd_cnt == RD_LAT) ? 0 : rd_cnt + 1;
    mem_rdata = (rd_cnt == RD_LAT) ? rd_word : JUNK;
  end

  // Memory-side monitor.
  always @(negedge clk) begin
    #1;
    if (mem_en === 1'b1) begin
      if (mem_q.size() == 0) begin
        check("unexpected_mem_en", 64'(mem_en), 64'd0);
      end else begin
        automatic mem_t e = mem_q.pop_front();
        check("mem_cycle", 64'(cyc), 64'(e.cyc));
        check("mem_addr", mem_addr, e.addr);
        check("mem_rw", 64'(mem_rw), 64'(e.rw));
        check("mem_be", 64'(mem_be), 64'(e.be));
        if (e.rw) check("mem_wdata", 64'(mem_wdata[31:0]), 64'(e.wd));
      end
    end
  end

  // Response monitor: data must stay stable every cycle until the handshake pops it.
  always @(negedge clk) begin
    #1;
    if (rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        if (!prev_v) check("rsp_cycle", 64'(cyc), 64'(rsp_q[0].cyc));
        check("rsp_data", rsp_data, rsp_q[0].data);
        check("rsp_err", 64'(rsp_err), 64'(rsp_q[0].err));
        if (rsp_ready) void'(rsp_q.pop_front());
      end
    end
    prev_v = (rsp_valid === 1'b1) && !rsp_ready;
  end

  task automatic drain();
    int n = 0;
    while ((mem_q.size() != 0 || rsp_q.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_pending", 64'(mem_q.size() + rsp_q.size()), 64'd0);
  endtask

  // hold: cycles rsp_ready stays low after rsp_valid; abort: reset during the load wait.
  task automatic do_req(input vec_t v, input int hold, input bit abort);
    int   n = 0;
    int   t;
    bit   trap = 1'b0;
    mem_t m;
    rsp_t r;
`ifdef DMR_MISALIGN_TRAP_EN
    trap = v.mis;
`endif
    rsp_ready = (hold == 0);
    do begin
      @(negedge clk);
      n++;
    end while (req_ready !== 1'b1 && n < 20);
    check("req_ready_wait", 64'(req_ready), 64'd1);
    t = cyc;
    rd_word    = v.rdata;
    req_valid  = 1'b1;
    req_rw     = v.rw;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    if (!trap) begin
      m.addr = {v.addr[63:2], 2'b00};
      m.rw   = v.rw;
      m.be   = v.rw ? v.be : 4'b0000;
      m.wd   = v.wd;
      m.cyc  = t + 1;
      mem_q.push_back(m);
    end
    if (!abort) begin
      r.data = trap ? 64'd0 : v.data;
      r.err  = trap;
      r.cyc  = trap ? t + 1 : (v.rw ? t + 2 : t + 2 + RD_LAT);
      rsp_q.push_back(r);
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
    if (abort) begin
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_req_ready", 64'(req_ready), 64'd1);
      check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    end else if (hold > 0) begin
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("hold_rsp_seen", 64'(rsp_valid), 64'd1);
      for (int k = 0; k < hold; k++) begin
        check("hold_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("post_hs_req_ready", 64'(req_ready), 64'd1);
      check("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    drain();
  endtask

  function automatic vec_t mk(bit rw, bit [1:0] sz, bit sg, logic [63:0] a, logic [63:0] wd,
                              logic [31:0] rd, logic [3:0] be, logic [31:0] mwd,
                              logic [63:0] d, bit mis);
    vec_t v;
    v.rw = rw; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd; v.rdata = rd;
    v.be = be; v.wd = mwd; v.data = d; v.mis = mis;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_rw", 64'(mem_rw), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_mem_be", 64'(mem_be), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_req_ready", 64'(req_ready), 64'd1);

    vecs.push_back(mk(1, 2'b10, 0, 64'h10, 64'hDEADBEEF, JUNK, 4'b1111, 32'hDEADBEEF, 64'd0, 0));
    vecs.push_back(mk(0, 2'b00, 1, 64'h13, 64'd0, 32'h80FF_1234, 4'b0000, 32'd0, 64'hFFFF_FFFF_FFFF_FF80, 0));
    vecs.push_back(mk(0, 2'b00, 0, 64'h13, 64'd0, 32'h80FF_1234, 4'b0000, 32'd0, 64'h80, 0));
    vecs.push_back(mk(1, 2'b00, 0, 64'h31, 64'h1122_3344_5566_7788, JUNK, 4'b0010, 32'h0000_8800, 64'd0, 0));
    vecs.push_back(mk(1, 2'b01, 0, 64'h42, 64'hCAFE_BEEF, JUNK, 4'b1100, 32'hBEEF_0000, 64'd0, 0));
    vecs.push_back(mk(1, 2'b00, 0, 64'h33, 64'h0000_00A5, JUNK, 4'b1000, 32'hA500_0000, 64'd0, 0));
    vecs.push_back(mk(1, 2'b01, 1, 64'h40, 64'hFFFF_0000_5678_1234, JUNK, 4'b0011, 32'h0000_1234, 64'd0, 0));
    vecs.push_back(mk(0, 2'b01, 0, 64'h40, 64'd0, 32'h1234_F00D, 4'b0000, 32'd0, 64'h0000_0000_0000_F00D, 0));
    vecs.push_back(mk(0, 2'b10, 1, 64'h44, 64'd0, 32'h8000_0001, 4'b0000, 32'd0, 64'hFFFF_FFFF_8000_0001, 0));
    vecs.push_back(mk(0, 2'b10, 0, 64'h48, 64'd0, 32'h8000_0001, 4'b0000, 32'd0, 64'h0000_0000_8000_0001, 0));
    vecs.push_back(mk(0, 2'b00, 0, 64'h51, 64'd0, 32'h1122_33C4, 4'b0000, 32'd0, 64'h33, 0));
    vecs.push_back(mk(0, 2'b00, 1, 64'h52, 64'd0, 32'h11C2_33C4, 4'b0000, 32'd0, 64'hFFFF_FFFF_FFFF_FFC2, 0));
    vecs.push_back(mk(0, 2'b11, 1, 64'h80, 64'd0, 32'hFEDC_BA98, 4'b0000, 32'd0, 64'hFFFF_FFFF_FEDC_BA98, 0));
    vecs.push_back(mk(0, 2'b01, 1, 64'h63, 64'd0, 32'hA5B6_C7D8, 4'b0000, 32'd0, 64'hFFFF_FFFF_FFFF_A5B6, 1));
    vecs.push_back(mk(0, 2'b10, 0, 64'h05, 64'd0, 32'h1357_9BDF, 4'b0000, 32'd0, 64'h0000_0000_1357_9BDF, 1));
    vecs.push_back(mk(1, 2'b10, 0, 64'h72, 64'h0102_0304, JUNK, 4'b1111, 32'h0102_0304, 64'd0, 1));

    foreach (vecs[i]) do_req(vecs[i], 0, 1'b0);

    // Back-pressure: response held for three cycles with rsp_ready low.
    do_req(mk(0, 2'b01, 1, 64'h22, 64'd0, 32'h8001_7FFF, 4'b0000, 32'd0, 64'hFFFF_FFFF_FFFF_8001, 0), 3, 1'b0);

    // Reset while the load waits for read data, then a normal access.
    do_req(mk(0, 2'b00, 1, 64'h13, 64'd0, 32'h80FF_1234, 4'b0000, 32'd0, 64'd0, 0), 0, 1'b1);
    do_req(mk(0, 2'b00, 1, 64'h13, 64'd0, 32'h80FF_1234, 4'b0000, 32'd0, 64'hFFFF_FFFF_FFFF_FF80, 0), 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
